// File: rtl/wash_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : wash_sequencer_if
// Brief   : Switch input and status/display outputs of the wash sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface wash_sequencer_if;
    logic       on;
    logic [1:0] phase;
    logic [3:0] n3;
    logic [3:0] n2;
    logic [3:0] n1;
    logic [3:0] n0;
    logic       busy;
    logic       paused;
    logic       done;
    logic       done_pulse;

    modport master (
        output on,
        input  phase, n3, n2, n1, n0, busy, paused, done, done_pulse
    );

    modport slave (
        input  on,
        output phase, n3, n2, n1, n0, busy, paused, done, done_pulse
    );
endinterface
`default_nettype wire

// File: rtl/wash_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : wash_sequencer
// Brief   : Wash -> rinse -> spin program timer with pause and BCD countdown.
// Revision: 1.0 - initial release
// ============================================================================
module wash_sequencer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int WASH_S   = 30,
    parameter int RINSE_S  = 20,
    parameter int SPIN_S   = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    wash_sequencer_if.slave bus
);

    localparam int c_sum = WASH_S + RINSE_S + SPIN_S;
    localparam int c_pw  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_pw-1:0] c_presc_max = c_pw'(TICK_DIV - 1);
    localparam logic [15:0] c_prog_bcd = {4'(c_sum / 1000), 4'((c_sum / 100) % 10),
                                          4'((c_sum / 10) % 10), 4'(c_sum % 10)};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WASH  = 3'd1,
        S_RINSE = 3'd2,
        S_SPIN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state, w_state_nx;
    logic            r_paused, w_paused_nx;
    logic            r_on_q;
    logic            r_done_pulse;
    logic [c_pw-1:0] r_presc, w_presc_nx;
    logic [6:0]      r_rem, w_rem_nx;
    logic [15:0]     r_bcd, w_bcd_nx;
    logic            w_start;
    logic            w_run;
    logic            w_tick;

    assign w_start = bus.on & ~r_on_q;
    assign w_run   = (r_state == S_WASH) || (r_state == S_RINSE) || (r_state == S_SPIN);
    assign w_tick  = w_run && !r_paused && (r_presc == c_presc_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_paused     <= 1'b0;
            r_on_q       <= 1'b0;
            r_presc      <= '0;
            r_rem        <= 7'd0;
            r_bcd        <= c_prog_bcd;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_paused     <= w_paused_nx;
            r_on_q       <= bus.on;
            r_presc      <= w_presc_nx;
            r_rem        <= w_rem_nx;
            r_bcd        <= w_bcd_nx;
            r_done_pulse <= (w_state_nx == S_DONE) && (r_state != S_DONE);
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_paused_nx = r_paused;
        w_presc_nx  = r_presc;
        w_rem_nx    = r_rem;
        w_bcd_nx    = r_bcd;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nx  = S_WASH;
                    w_rem_nx    = 7'(WASH_S);
                    w_presc_nx  = '0;
                    w_paused_nx = 1'b0;
                end
            end
            S_WASH, S_RINSE, S_SPIN: begin
                if (!r_paused) begin
                    w_presc_nx = w_tick ? '0 : r_presc + c_pw'(1);
                end
                // Tick is applied before the pause toggle of the same edge.
                if (start_toggles()) begin
                    w_paused_nx = ~r_paused;
                end
                if (w_tick) begin
                    if (r_bcd != 16'h0000) begin
                        if (r_bcd[3:0] != 4'd0) begin
                            w_bcd_nx[3:0] = r_bcd[3:0] - 4'd1;
                        end else begin
                            w_bcd_nx[3:0] = 4'd9;
                            if (r_bcd[7:4] != 4'd0) begin
                                w_bcd_nx[7:4] = r_bcd[7:4] - 4'd1;
                            end else begin
                                w_bcd_nx[7:4] = 4'd9;
                                if (r_bcd[11:8] != 4'd0) begin
                                    w_bcd_nx[11:8] = r_bcd[11:8] - 4'd1;
                                end else begin
                                    w_bcd_nx[11:8]  = 4'd9;
                                    w_bcd_nx[15:12] = r_bcd[15:12] - 4'd1;
                                end
                            end
                        end
                    end
                    if (r_rem > 7'd1) begin
                        w_rem_nx = r_rem - 7'd1;
                    end else if (r_state == S_WASH) begin
                        w_state_nx = S_RINSE;
                        w_rem_nx   = 7'(RINSE_S);
                    end else if (r_state == S_RINSE) begin
                        w_state_nx = S_SPIN;
                        w_rem_nx   = 7'(SPIN_S);
                    end else begin
                        w_state_nx  = S_DONE;
                        w_rem_nx    = 7'd0;
                        w_paused_nx = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (w_start) begin
                    w_state_nx = S_IDLE;
                    w_bcd_nx   = c_prog_bcd;
                end
            end
            default: begin
                w_state_nx  = S_IDLE;
                w_paused_nx = 1'b0;
                w_presc_nx  = '0;
                w_rem_nx    = 7'd0;
                w_bcd_nx    = c_prog_bcd;
            end
        endcase
    end

    function automatic logic start_toggles();
        return w_start;
    endfunction

    always_comb begin
        case (r_state)
            S_WASH:  bus.phase = 2'b00;
            S_RINSE: bus.phase = 2'b01;
            S_SPIN:  bus.phase = 2'b10;
            default: bus.phase = 2'b11;
        endcase
    end

    assign bus.n3         = r_bcd[15:12];
    assign bus.n2         = r_bcd[11:8];
    assign bus.n1         = r_bcd[7:4];
    assign bus.n0         = r_bcd[3:0];
    assign bus.busy       = w_run;
    assign bus.paused     = w_run & r_paused;
    assign bus.done       = (r_state == S_DONE);
    assign bus.done_pulse = r_done_pulse;

endmodule
`default_nettype wire

// File: tb/tb_wash_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_wash_sequencer
// Brief   : Self-checking bench for wash_sequencer (small and BCD-borrow builds).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wash_sequencer;

    localparam int TD  = 4;
    localparam int WS  = 2;
    localparam int RS  = 1;
    localparam int SS  = 1;
    localparam int SUM = WS + RS + SS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    wash_sequencer_if ifa ();
    wash_sequencer_if ifb ();

    wash_sequencer #(.TICK_DIV(TD), .WASH_S(WS), .RINSE_S(RS), .SPIN_S(SS)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    wash_sequencer #(.TICK_DIV(2), .WASH_S(99), .RINSE_S(99), .SPIN_S(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    logic [15:0] dig_a;
    logic [15:0] dig_b;
    logic [21:0] obs_a;
    assign dig_a = {ifa.n3, ifa.n2, ifa.n1, ifa.n0};
    assign dig_b = {ifb.n3, ifb.n2, ifb.n1, ifb.n0};
    assign obs_a = {ifa.phase, dig_a, ifa.busy, ifa.paused, ifa.done, ifa.done_pulse};

    // Reference: counts unpaused running cycles; seconds elapsed = cycles / TD.
    int   m_mode;   // 0 idle, 1 running, 2 done
    int   m_cycles;
    logic m_onq;
    logic m_paused;
    logic m_pulse;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cycles = 0; m_onq = 1'b0; m_paused = 1'b0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic on_v);
        logic st;
        st      = on_v & ~m_onq;
        m_pulse = 1'b0;
        if (m_mode == 0) begin
            if (st) begin m_mode = 1; m_cycles = 0; m_paused = 1'b0; end
        end else if (m_mode == 1) begin
            if (!m_paused) m_cycles++;
            if (m_cycles / TD >= SUM) begin
                m_mode = 2; m_paused = 1'b0; m_pulse = 1'b1;
            end else if (st) begin
                m_paused = ~m_paused;
            end
        end else begin
            if (st) m_mode = 0;
        end
        m_onq = on_v;
    endtask

    function automatic logic [21:0] model_out();
        int secs, rem;
        logic [1:0] ph;
        secs = m_cycles / TD;
        if (m_mode == 1) begin
            rem = SUM - secs;
            ph  = (secs < WS) ? 2'd0 : ((secs < WS + RS) ? 2'd1 : 2'd2);
        end else begin
            rem = (m_mode == 0) ? SUM : 0;
            ph  = 2'b11;
        end
        return {ph, to_bcd(rem), (m_mode == 1), (m_mode == 1) && m_paused, (m_mode == 2), m_pulse};
    endfunction

    task automatic drive_a(input logic v);
        ifa.on = v;
        @(posedge clk);
        model_step(v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        ifa.on = 1'b0;
        ifb.on = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ifa.on = 1'b0;
        ifb.on = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++;
        if ({ifa.phase, dig_a} !== {2'b11, 16'h0004}) begin
            miscompares++;
            $display("FAIL reset_idle_a: got phase=%b dig=%h, want phase=11 dig=0004", ifa.phase, dig_a);
        end
        vectors++;
        if ({ifa.busy, ifa.paused, ifa.done, ifa.done_pulse} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags_a: got %b, want 0000",
                     {ifa.busy, ifa.paused, ifa.done, ifa.done_pulse});
        end
        vectors++;
        if ({ifb.phase, dig_b} !== {2'b11, 16'h0200}) begin
            miscompares++;
            $display("FAIL reset_idle_b: got phase=%b dig=%h, want phase=11 dig=0200", ifb.phase, dig_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(1'b0);
        vectors++;
        if (obs_a !== model_out()) begin
            miscompares++;
            $display("FAIL idle_hold: got %h, want %h", obs_a, model_out());
        end
    endtask

    task automatic test_full_cycle();
        do_reset();
        for (int e = 0; e <= 17; e++) begin
            drive_a(1'b1);
            vectors++;
            if (obs_a !== model_out()) begin
                miscompares++;
                $display("FAIL full_model e=%0d: got %h, want %h", e, obs_a, model_out());
            end
            if (e == 4 || e == 8 || e == 12) begin
                vectors++;
                if ({ifa.phase, dig_a} !== {2'(e / 4 - 1), to_bcd(4 - e / 4)}) begin
                    miscompares++;
                    $display("FAIL full_edge%0d: got phase=%b dig=%h, want phase=%b dig=%h",
                             e, ifa.phase, dig_a, 2'(e / 4 - 1), to_bcd(4 - e / 4));
                end
            end
            if (e == 16) begin
                vectors++;
                if ({ifa.phase, dig_a, ifa.done, ifa.done_pulse} !== {2'b11, 16'h0000, 2'b11}) begin
                    miscompares++;
                    $display("FAIL full_done: got phase=%b dig=%h done=%b pulse=%b, want 11 0000 1 1",
                             ifa.phase, dig_a, ifa.done, ifa.done_pulse);
                end
            end
            if (e == 17) begin
                vectors++;
                if ({ifa.done, ifa.done_pulse} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL full_pulse_width: got done=%b pulse=%b, want 1 0", ifa.done, ifa.done_pulse);
                end
            end
        end
        drive_a(1'b0);
        drive_a(1'b1);
        vectors++;
        if ({ifa.phase, dig_a, ifa.done} !== {2'b11, 16'h0004, 1'b0}) begin
            miscompares++;
            $display("FAIL done_to_idle: got phase=%b dig=%h done=%b, want 11 0004 0", ifa.phase, dig_a, ifa.done);
        end
    endtask

    task automatic test_pause();
        do_reset();
        drive_a(1'b1);
        drive_a(1'b0);
        drive_a(1'b1);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({ifa.paused, ifa.busy, dig_a} !== {2'b11, 16'h0004}) begin
                miscompares++;
                $display("FAIL pause_hold i=%0d: got paused=%b busy=%b dig=%h, want 1 1 0004",
                         i, ifa.paused, ifa.busy, dig_a);
            end
            drive_a(1'b1);
        end
        drive_a(1'b0);
        drive_a(1'b1);
        vectors++;
        if ({ifa.paused, dig_a} !== {1'b0, 16'h0004}) begin
            miscompares++;
            $display("FAIL pause_resume: got paused=%b dig=%h, want 0 0004", ifa.paused, dig_a);
        end
        drive_a(1'b1);
        vectors++;
        if (dig_a !== 16'h0004) begin
            miscompares++;
            $display("FAIL pause_early_tick: got dig=%h, want 0004", dig_a);
        end
        drive_a(1'b1);
        vectors++;
        if ({ifa.phase, dig_a} !== {2'b00, 16'h0003}) begin
            miscompares++;
            $display("FAIL pause_first_tick: got phase=%b dig=%h, want 00 0003", ifa.phase, dig_a);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive_a(1'b1);
        drive_a(1'b0);
        drive_a(1'b0);
        drive_a(1'b0);
        drive_a(1'b1);
        vectors++;
        if ({ifa.paused, dig_a} !== {1'b1, 16'h0003}) begin
            miscompares++;
            $display("FAIL simul_tick_pause: got paused=%b dig=%h, want 1 0003", ifa.paused, dig_a);
        end
        for (int i = 0; i < 5; i++) drive_a(1'b1);
        vectors++;
        if ({ifa.paused, dig_a} !== {1'b1, 16'h0003}) begin
            miscompares++;
            $display("FAIL simul_frozen: got paused=%b dig=%h, want 1 0003", ifa.paused, dig_a);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int e = 0; e <= 9; e++) drive_a(1'b1);
        vectors++;
        if (ifa.phase !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_in_rinse: got phase=%b, want 01", ifa.phase);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ifa.phase, dig_a, ifa.busy} !== {2'b11, 16'h0004, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_async_reset: got phase=%b dig=%h busy=%b, want 11 0004 0",
                     ifa.phase, dig_a, ifa.busy);
        end
        ifa.on = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e <= 16; e++) begin
            drive_a(1'b1);
            vectors++;
            if (ifa.done !== (e == 16)) begin
                miscompares++;
                $display("FAIL mid_rerun e=%0d: got done=%b, want %b", e, ifa.done, (e == 16));
            end
        end
    endtask

    task automatic test_random();
        logic v;
        do_reset();
        v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) v = ~v;
            drive_a(v);
            vectors++;
            if (obs_a !== model_out()) begin
                miscompares++;
                $display("FAIL random i=%0d: got %h, want %h", i, obs_a, model_out());
            end
        end
    endtask

    task automatic test_bcd_borrow();
        int secs;
        logic [1:0] ph;
        do_reset();
        ifb.on = 1'b1;
        for (int e = 0; e <= 200; e++) begin
            @(posedge clk);
            @(negedge clk);
            secs = e / 2;
            ph   = (secs < 99) ? 2'd0 : ((secs < 198) ? 2'd1 : 2'd2);
            vectors++;
            if ({ifb.phase, dig_b} !== {ph, to_bcd(200 - secs)}) begin
                miscompares++;
                $display("FAIL bcd_borrow e=%0d: got phase=%b dig=%h, want phase=%b dig=%h",
                         e, ifb.phase, dig_b, ph, to_bcd(200 - secs));
            end
        end
        ifb.on = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ifa.on = 1'b0;
        ifb.on = 1'b0;
        model_reset();
        test_reset();
        test_full_cycle();
        test_pause();
        test_simultaneous();
        test_reset_mid();
        test_random();
        test_bcd_borrow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
